// File: rtl/fetch_unit.sv
// Byte-serial instruction fetch: opcode, register byte, optional little-endian immediate, valid/ready to decode.
// Optional macro FETCH_SKIP_NOP_EN: opcode 8'h00 is fetched in full but never presented.
module fetch_unit #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int                IMM_BYTES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   mem_req,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic                   mem_ready,
  input  logic [7:0]             mem_rdata,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [7:0]             opcode,
  output logic [3:0]             rdest,
  output logic [3:0]             rsrc1,
  output logic [8*IMM_BYTES-1:0] immediate,
  output logic [ADDR_W-1:0]      instr_pc,
  output logic [ADDR_W-1:0]      next_pc,
  input  logic                   jump_valid,
  input  logic [ADDR_W-1:0]      jump_target,
  input  logic                   halt
);
  typedef enum logic [2:0] {FETCH_OP, FETCH_REG, FETCH_IMM, PRESENT, HALTED} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_inc;
  logic [2:0]        byte_cnt;
  logic              started, accept, handshake, has_imm, last_imm, skip_nop;

  assign pc_inc      = pc + ADDR_W'(1);
  assign has_imm     = opcode[5] | opcode[6];
  assign last_imm    = (byte_cnt == 3'(IMM_BYTES - 1));
`ifdef FETCH_SKIP_NOP_EN
  assign skip_nop    = (opcode == 8'h00);
`else
  assign skip_nop    = 1'b0;
`endif
  // started keeps mem_req low for the first cycle after reset release
  assign mem_req     = started && (state == FETCH_OP || state == FETCH_REG || state == FETCH_IMM);
  assign mem_addr    = pc;
  assign accept      = mem_req && mem_ready;
  assign instr_valid = (state == PRESENT);
  assign handshake   = instr_valid && instr_ready;

  always_ff @(posedge clk) begin
    if (!rst) state <= FETCH_OP;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH_OP:  if (accept) state_nxt = FETCH_REG;
      FETCH_REG: begin
        if (accept) begin
          if (has_imm)       state_nxt = FETCH_IMM;
          else if (skip_nop) state_nxt = FETCH_OP;
          else               state_nxt = PRESENT;
        end
      end
      FETCH_IMM: if (accept && last_imm) state_nxt = PRESENT;
      PRESENT:   if (handshake) state_nxt = halt ? HALTED : FETCH_OP;
      HALTED:    state_nxt = HALTED;
      default:   state_nxt = FETCH_OP;
    endcase
    // a redirect overrides everything; a same-cycle handshake has already been consumed
    if (jump_valid) state_nxt = FETCH_OP;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      started   <= 1'b0;
      pc        <= RESET_PC;
      byte_cnt  <= '0;
      opcode    <= '0;
      rdest     <= '0;
      rsrc1     <= '0;
      immediate <= '0;
      instr_pc  <= '0;
      next_pc   <= '0;
    end else begin
      started <= 1'b1;
      if (jump_valid) begin
        pc       <= jump_target;
        byte_cnt <= '0;
      end else if (accept) begin
        pc <= pc_inc;
        case (state)
          FETCH_OP: begin
            opcode    <= mem_rdata;
            instr_pc  <= pc;
            immediate <= '0;
            byte_cnt  <= '0;
          end
          FETCH_REG: begin
            rdest <= mem_rdata[7:4];
            rsrc1 <= mem_rdata[3:0];
            if (!has_imm) next_pc <= pc_inc;
          end
          FETCH_IMM: begin
            immediate[{byte_cnt, 3'b000} +: 8] <= mem_rdata;
            byte_cnt <= byte_cnt + 3'd1;
            if (last_imm) next_pc <= pc_inc;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: vector table, multi-cycle corner sequences, randomized stream vs. a decode model.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst, mem_req, mem_ready, instr_valid, instr_ready, jump_valid, halt;
  logic [31:0] mem_addr, immediate, instr_pc, next_pc, jump_target;
  logic [7:0]  mem_rdata, opcode;
  logic [3:0]  rdest, rsrc1;
  logic [7:0]  mem [0:1023];

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_addr[9:0]];

  fetch_unit dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .rdest(rdest), .rsrc1(rsrc1), .immediate(immediate),
    .instr_pc(instr_pc), .next_pc(next_pc), .jump_valid(jump_valid),
    .jump_target(jump_target), .halt(halt)
  );

  typedef struct {
    logic [47:0] bytes;
    int          len;
    logic [7:0]  op;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [31:0] imm;
    int          lat;
  } vec_t;

  typedef struct {
    logic [7:0]  op;
    logic [7:0]  rg;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] npc;
  } exp_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load(input int base, input logic [47:0] b, input int n);
    for (int i = 0; i < n; i++) mem[10'(base + i)] = b[8*i +: 8];
  endtask

  task automatic do_reset();
    rst = 1'b0; jump_valid = 1'b0; halt = 1'b0; instr_ready = 1'b0; mem_ready = 1'b1;
    jump_target = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_req",     64'(mem_req),     64'h0);
    check("rst_instr_valid", 64'(instr_valid), 64'h0);
    check("rst_opcode",      64'(opcode),      64'h0);
    check("rst_immediate",   64'(immediate),   64'h0);
    check("rst_pc",          64'(mem_addr),    64'h0);
    check("rst_next_pc",     64'(next_pc),     64'h0);
    rst = 1'b1;
  endtask

  task automatic wait_valid(input int budget, output int cyc);
    cyc = 0;
    while (!instr_valid && cyc < budget) begin
      @(posedge clk); #1; cyc++;
    end
    if (!instr_valid) begin
      tests++; failed++;
      $display("FAIL wait_valid: no instr_valid within %0d cycles", budget);
    end
  endtask

  vec_t vecs [6];
  exp_t exp_q [$];
  exp_t e;

  initial begin
    int cyc, nacc, p;
    logic pq, pr;
    logic [7:0] op, rg;
    logic [31:0] imm;

    vecs[0] = '{48'h0000_0000_1280, 2, 8'h80, 4'h1, 4'h2, 32'h0,        3};
    vecs[1] = '{48'h1234_5678_34A0, 6, 8'hA0, 4'h3, 4'h4, 32'h12345678, 7};
    vecs[2] = '{48'hDEAD_BEEF_0040, 6, 8'h40, 4'h0, 4'h0, 32'hDEADBEEF, 7};
    vecs[3] = '{48'h0000_0001_AB20, 6, 8'h20, 4'hA, 4'hB, 32'h00000001, 7};
    vecs[4] = '{48'h0000_0000_C31F, 2, 8'h1F, 4'hC, 4'h3, 32'h0,        3};
    vecs[5] = '{48'h4433_2211_7760, 6, 8'h60, 4'h7, 4'h7, 32'h44332211, 7};

    for (int i = 0; i < 1024; i++) mem[i] = 8'h80;

    for (int v = 0; v < 6; v++) begin
      load(0, vecs[v].bytes, vecs[v].len);
      do_reset();
      wait_valid(40, cyc);
      check("vec_latency",   64'(cyc),       64'(vecs[v].lat));
      check("vec_opcode",    64'(opcode),    64'(vecs[v].op));
      check("vec_rdest",     64'(rdest),     64'(vecs[v].rd));
      check("vec_rsrc1",     64'(rsrc1),     64'(vecs[v].rs));
      check("vec_immediate", 64'(immediate), 64'(vecs[v].imm));
      check("vec_instr_pc",  64'(instr_pc),  64'h0);
      check("vec_next_pc",   64'(next_pc),   64'(vecs[v].len));
      check("vec_mem_req",   64'(mem_req),   64'h0);
    end

    // Decode stalls for 5 cycles while an instruction is presented
    load(0, 48'h0000_779A_1280, 4);
    do_reset();
    wait_valid(40, cyc);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("hold_valid",   64'(instr_valid), 64'h1);
      check("hold_opcode",  64'(opcode),      64'h80);
      check("hold_next_pc", 64'(next_pc),     64'h2);
      check("hold_mem_req", 64'(mem_req),     64'h0);
      check("hold_pc",      64'(mem_addr),    64'h2);
    end
    instr_ready = 1'b1;
    @(posedge clk); #1;
    instr_ready = 1'b0;
    check("hs_valid_drop", 64'(instr_valid), 64'h0);
    check("hs_mem_req",    64'(mem_req),     64'h1);
    check("hs_mem_addr",   64'(mem_addr),    64'h2);
    wait_valid(40, cyc);
    check("second_opcode", 64'(opcode),   64'h9A);
    check("second_pc",     64'(instr_pc), 64'h2);

    // mem_ready toggling through an immediate fetch
    load(0, vecs[1].bytes, 6);
    do_reset();
    instr_ready = 1'b0;
    mem_ready = 1'b0;
    cyc = 0; nacc = 0;
    while (!instr_valid && cyc < 60) begin
      pq = mem_req; pr = mem_ready;
      @(posedge clk); #1; cyc++;
      if (pq && pr) nacc++;
      if (mem_req) check("stall_mem_addr", 64'(mem_addr), 64'(nacc));
      mem_ready = ~mem_ready;
    end
    check("stall_valid",     64'(instr_valid), 64'h1);
    check("stall_opcode",    64'(opcode),      64'hA0);
    check("stall_immediate", 64'(immediate),   64'h12345678);
    check("stall_next_pc",   64'(next_pc),     64'h6);

    // Jump in the middle of an immediate, then halt, then resume by jump
    load(0, vecs[1].bytes, 6);
    load(32'h100, 48'h5580, 2);
    load(32'h200, 48'hC31F, 2);
    do_reset();
    instr_ready = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    jump_valid = 1'b1; jump_target = 32'h100;
    @(posedge clk); #1;
    jump_valid = 1'b0;
    check("jmp_mem_addr", 64'(mem_addr),    64'h100);
    check("jmp_mem_req",  64'(mem_req),     64'h1);
    check("jmp_valid",    64'(instr_valid), 64'h0);
    wait_valid(40, cyc);
    check("jmp_opcode",    64'(opcode),    64'h80);
    check("jmp_instr_pc",  64'(instr_pc),  64'h100);
    check("jmp_next_pc",   64'(next_pc),   64'h102);
    check("jmp_immediate", 64'(immediate), 64'h0);
    halt = 1'b1;
    @(posedge clk); #1;
    halt = 1'b0;
    check("halt_valid",   64'(instr_valid), 64'h0);
    check("halt_mem_req", 64'(mem_req),     64'h0);
    repeat (3) begin @(posedge clk); #1; end
    check("halted_mem_req", 64'(mem_req), 64'h0);
    jump_valid = 1'b1; jump_target = 32'h200;
    @(posedge clk); #1;
    jump_valid = 1'b0;
    check("resume_mem_req",  64'(mem_req),  64'h1);
    check("resume_mem_addr", 64'(mem_addr), 64'h200);
    wait_valid(40, cyc);
    check("resume_opcode", 64'(opcode),   64'h1F);
    check("resume_pc",     64'(instr_pc), 64'h200);

    // Jump, halt and handshake together: jump wins over halt; target wraps the PC
    mem[1023] = 8'h80; mem[0] = 8'h12;
    jump_valid = 1'b1; jump_target = 32'hFFFF_FFFF; halt = 1'b1;
    @(posedge clk); #1;
    jump_valid = 1'b0; halt = 1'b0;
    check("jhs_valid",    64'(instr_valid), 64'h0);
    check("jhs_mem_req",  64'(mem_req),     64'h1);
    check("jhs_mem_addr", 64'(mem_addr),    64'hFFFF_FFFF);
    wait_valid(40, cyc);
    check("wrap_opcode",   64'(opcode),   64'h80);
    check("wrap_rdest",    64'(rdest),    64'h1);
    check("wrap_instr_pc", 64'(instr_pc), 64'hFFFF_FFFF);
    check("wrap_next_pc",  64'(next_pc),  64'h1);

    // NOP handling
    load(0, 48'h0000_1180_0000, 4);
    do_reset();
    wait_valid(40, cyc);
`ifdef FETCH_SKIP_NOP_EN
    check("nop_opcode",   64'(opcode),   64'h80);
    check("nop_instr_pc", 64'(instr_pc), 64'h2);
`else
    check("nop_opcode",   64'(opcode),   64'h00);
    check("nop_instr_pc", 64'(instr_pc), 64'h0);
`endif

    // Randomized stream with random memory and decode stalls
    p = 0;
    for (int n = 0; n < 30; n++) begin
      op  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      rg  = 8'($urandom);
      imm = (op[5] | op[6]) ? $urandom : 32'h0;
      mem[10'(p)] = op; mem[10'(p + 1)] = rg;
      if (op[5] | op[6])
        for (int k = 0; k < 4; k++) mem[10'(p + 2 + k)] = imm[8*k +: 8];
      e = '{op, rg, imm, 32'(p), 32'(p + ((op[5] | op[6]) ? 6 : 2))};
`ifdef FETCH_SKIP_NOP_EN
      if (op != 8'h00) exp_q.push_back(e);
`else
      exp_q.push_back(e);
`endif
      p = 32'(e.npc);
    end
    do_reset();
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 4000) begin
      @(posedge clk); #1; cyc++;
      mem_ready   = ($urandom_range(0, 3) != 0);
      instr_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (instr_valid && instr_ready) begin
        e = exp_q.pop_front();
        check("rnd_opcode",    64'(opcode),          64'(e.op));
        check("rnd_regs",      64'({rdest, rsrc1}),  64'(e.rg));
        check("rnd_immediate", 64'(immediate),       64'(e.imm));
        check("rnd_instr_pc",  64'(instr_pc),        64'(e.pc));
        check("rnd_next_pc",   64'(next_pc),         64'(e.npc));
      end
    end
    if (exp_q.size() != 0) begin
      tests++; failed++;
      $display("FAIL rnd_timeout: %0d instructions never presented", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the control unit.
- Reads the byte-serial instruction stream from instruction memory and assembles each variable-length instruction: opcode, register byte, and an optional 32-bit little-endian immediate.
- Presents each instruction through a valid/ready handshake to decode (CU opcode input, register file indices, immediate path).
- Tracks the PC and accepts jump redirects from execute.

Parameters:
ADDR_W, 32, width of PC and memory byte address
RESET_PC, 0, PC loaded on reset
IMM_BYTES, 4, trailing immediate length in bytes (1..4)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-low (asserted when 0)
mem_req  out  1  byte read request
mem_addr  out  ADDR_W  byte address of request
mem_ready  in  1  mem_rdata valid; byte accepted on cycles with mem_req && mem_ready
mem_rdata  in  8  read byte
instr_valid  out  1  assembled instruction available
instr_ready  in  1  decode accepts instruction when instr_valid && instr_ready
opcode  out  8  instruction opcode
rdest  out  4  register byte [7:4]
rsrc1  out  4  register byte [3:0]
immediate  out  8*IMM_BYTES  immediate, zero if absent
instr_pc  out  ADDR_W  address of opcode byte
next_pc  out  ADDR_W  address following the full instruction
jump_valid  in  1  redirect request, single-cycle pulse
jump_target  in  ADDR_W  redirect address
halt  in  1  CU halt; stops fetch after current handshake

Behaviour:
- Reset (rst==0 at edge): state=FETCH_OP, pc=RESET_PC, mem_req=0, instr_valid=0, opcode/rdest/rsrc1/immediate/instr_pc/next_pc=0. mem_req rises the cycle after reset deasserts.
- Immediate present iff opcode[5] | opcode[6]. Instruction length is 2 bytes without immediate, 2+IMM_BYTES with it.
- States: FETCH_OP -> FETCH_REG -> (FETCH_IMM if immediate present, else PRESENT) -> PRESENT -> FETCH_OP; HALTED.
- mem_req=1 in FETCH_OP/FETCH_REG/FETCH_IMM only. mem_addr=pc.
- Each accepted byte advances pc by 1 and the FSM.
- mem_addr and mem_req stay stable while mem_ready=0.
- FETCH_OP captures opcode and latches instr_pc=pc. The immediate register is cleared here.
- FETCH_IMM: byte counter 0..IMM_BYTES-1; byte k goes into immediate[8k+7:8k] (little-endian). Exits after the last byte.
- PRESENT: instr_valid=1; all outputs held stable until handshake; next_pc=pc.
  - On handshake: go to FETCH_OP, or to HALTED if halt==1 in that cycle.
  - Minimum latency: last byte accepted at cycle N -> instr_valid at N+1. Back-to-back 2-byte instructions with mem_ready=1 give one instruction per 3 cycles.
- HALTED: mem_req=0, instr_valid=0. Leaves only via reset or jump_valid.
- jump_valid (any state):
  - Next cycle: pc=jump_target, state=FETCH_OP, instr_valid=0.
  - Any partially assembled instruction is discarded.
  - Any in-flight byte accepted in the same cycle is dropped.
  - A presented instruction not handshaken that cycle is dropped.
- Priority: reset > jump_valid > halt > normal progress.
- Simultaneous jump_valid and instr_valid&&instr_ready: the handshake completes (decode consumed it), then the redirect applies.
- PC wrap: pc increments modulo 2^ADDR_W; no error on wrap.

Optional Feature:
- Macro FETCH_SKIP_NOP_EN.
- Defined: an instruction with opcode 8'h00 is still fetched fully (both bytes, pc advances) but is not presented. The FSM goes FETCH_REG -> FETCH_OP directly, and instr_valid never asserts for NOP.
- Undefined: NOP is presented like any other instruction.

Test Plan:
- Reset then memory 8'h80,8'h12 at 0 with mem_ready=1 -> instr_valid at cycle 3 after reset release; opcode=8'h80, rdest=1, rsrc1=2, immediate=0, instr_pc=0, next_pc=2.
- Bytes 8'hA0,8'h34,8'h78,8'h56,8'h34,8'h12 -> immediate=32'h12345678, next_pc=6. Bytes 8'h40,8'h00 + 4 bytes also fetch an immediate (opcode[6]).
- Hold instr_ready=0 for 5 cycles in PRESENT -> outputs stable, mem_req=0, no pc change; handshake on 6th cycle -> next fetch at next_pc.
- mem_ready toggling 0/1 every cycle during an immediate fetch -> same assembled values as the no-stall case; mem_addr stable while stalled.
- jump_valid with jump_target=32'h100 mid FETCH_IMM -> partial instruction discarded; next mem_addr=32'h100. Repeat with halt=1 at handshake -> HALTED, mem_req=0; a later jump_valid resumes at its target.
- Stream 8'h00,8'h00,8'h80,8'h11: with FETCH_SKIP_NOP_EN, the first presented opcode is 8'h80 with instr_pc=2. Without it, the NOP is presented first with instr_pc=0.
